// File: rtl/segment_display_monitor.sv
// Receive-side monitor for a 7-segment up/down counter display.
// Filters the segment bus for stability, decodes accepted patterns back to a
// decimal digit, classifies digit changes as +1 / -1 / jump steps, flags
// illegal patterns and keeps saturating counts of up and down steps.
module segment_display_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       segment,
   output logic [3:0]       digit,
   output logic             digit_valid,
   output logic             step_up,
   output logic             step_down,
   output logic             jump,
   output logic             illegal,
   output logic [6:0]       err_pattern,
   output logic [CNT_W-1:0] up_cnt,
   output logic [CNT_W-1:0] down_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [7:0]       STABLE_C = 8'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Decode a segment pattern into {legal, digit}; anything off-table is illegal.
   function automatic logic [4:0] decode_seg(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'h3F:   res = {1'b1, 4'd0};
         7'h06:   res = {1'b1, 4'd1};
         7'h5B:   res = {1'b1, 4'd2};
         7'h4F:   res = {1'b1, 4'd3};
         7'h66:   res = {1'b1, 4'd4};
         7'h6D:   res = {1'b1, 4'd5};
         7'h7D:   res = {1'b1, 4'd6};
         7'h07:   res = {1'b1, 4'd7};
         7'h7F:   res = {1'b1, 4'd8};
         7'h6F:   res = {1'b1, 4'd9};
         default: res = {1'b0, 4'd0};
      endcase
      return res;
   endfunction

   state_t           state_r;
   state_t           state_next_s;
   logic [6:0]       sample_r;
   logic [7:0]       run_r;
   logic [7:0]       run_next_s;
   logic [6:0]       last_pat_r;
   logic             accept_s;
   logic [4:0]       dec_s;
   logic [3:0]       digit_inc_s;
   logic [3:0]       digit_dec_s;
   logic [3:0]       digit_next_s;
   logic             valid_next_s;
   logic             up_next_s;
   logic             down_next_s;
   logic             jump_next_s;
   logic             illegal_next_s;
   logic [6:0]       err_next_s;
   logic [CNT_W-1:0] up_cnt_next_s;
   logic [CNT_W-1:0] down_cnt_next_s;

   // Stability filter: run length of identical samples and the acceptance strobe.
   always_comb begin
      run_next_s = run_r;
      if (segment != sample_r) begin
         run_next_s = 8'd1;
      end else if (run_r != STABLE_C) begin
         run_next_s = run_r + 8'd1;
      end else begin
         run_next_s = run_r;
      end
      // Accept only on the edge the run reaches the threshold, never while it sits there.
      accept_s = (run_next_s == STABLE_C)
               && !((run_r == STABLE_C) && (segment == sample_r))
               && ((state_r == IDLE) || (segment != last_pat_r));
      dec_s       = decode_seg(segment);
      digit_inc_s = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      digit_dec_s = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
   end

   // Next-state and next-output logic of the tracking FSM.
   always_comb begin
      state_next_s   = state_r;
      digit_next_s   = digit;
      valid_next_s   = digit_valid;
      up_next_s      = 1'b0;
      down_next_s    = 1'b0;
      jump_next_s    = 1'b0;
      illegal_next_s = illegal;
      err_next_s     = err_pattern;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (dec_s[4]) begin
                  digit_next_s = dec_s[3:0];
                  valid_next_s = 1'b1;
                  state_next_s = TRACK;
               end else begin
                  illegal_next_s = 1'b1;
                  err_next_s     = segment;
                  state_next_s   = FAULT;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         TRACK, FAULT: begin
            if (accept_s) begin
               if (dec_s[4]) begin
                  // With no retained digit this is the first acceptance: no pulse.
                  if (digit_valid) begin
                     if (dec_s[3:0] == digit_inc_s) begin
                        up_next_s = 1'b1;
                     end else if (dec_s[3:0] == digit_dec_s) begin
                        down_next_s = 1'b1;
                     end else if (dec_s[3:0] != digit) begin
                        jump_next_s = 1'b1;
                     end else begin
                        jump_next_s = 1'b0;
                     end
                  end else begin
                     jump_next_s = 1'b0;
                  end
                  digit_next_s   = dec_s[3:0];
                  valid_next_s   = 1'b1;
                  illegal_next_s = 1'b0;
                  state_next_s   = TRACK;
               end else begin
                  illegal_next_s = 1'b1;
                  err_next_s     = segment;
                  state_next_s   = FAULT;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
      up_cnt_next_s   = (up_next_s && (up_cnt != CNT_MAX)) ? up_cnt + CNT_ONE : up_cnt;
      down_cnt_next_s = (down_next_s && (down_cnt != CNT_MAX)) ? down_cnt + CNT_ONE : down_cnt;
   end

   // State, filter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         sample_r    <= 7'h00;
         run_r       <= 8'd0;
         last_pat_r  <= 7'h00;
         digit       <= 4'd0;
         digit_valid <= 1'b0;
         step_up     <= 1'b0;
         step_down   <= 1'b0;
         jump        <= 1'b0;
         illegal     <= 1'b0;
         err_pattern <= 7'h00;
         up_cnt      <= {CNT_W{1'b0}};
         down_cnt    <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_next_s;
         sample_r    <= segment;
         run_r       <= run_next_s;
         last_pat_r  <= accept_s ? segment : last_pat_r;
         digit       <= digit_next_s;
         digit_valid <= valid_next_s;
         step_up     <= up_next_s;
         step_down   <= down_next_s;
         jump        <= jump_next_s;
         illegal     <= illegal_next_s;
         err_pattern <= err_next_s;
         up_cnt      <= up_cnt_next_s;
         down_cnt    <= down_cnt_next_s;
      end
   end

endmodule

// File: tb/tb_segment_display_monitor.sv
// Scoreboard bench for segment_display_monitor: stimulus pushes the expected
// output set predicted by a behavioural model; a monitor pops and compares.
module tb_segment_display_monitor;

   localparam int S  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [6:0]    segment = 7'h00;
   logic [3:0]    digit;
   logic          digit_valid, step_up, step_down, jump, illegal;
   logic [6:0]    err_pattern;
   logic [CW-1:0] up_cnt, down_cnt;

   segment_display_monitor #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .segment(segment),
      .digit(digit), .digit_valid(digit_valid),
      .step_up(step_up), .step_down(step_down), .jump(jump),
      .illegal(illegal), .err_pattern(err_pattern),
      .up_cnt(up_cnt), .down_cnt(down_cnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]    digit;
      logic          valid;
      logic          up;
      logic          dn;
      logic          jmp;
      logic          ill;
      logic [6:0]    err;
      logic [CW-1:0] upc;
      logic [CW-1:0] dnc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // Reference model state: run length since reset, last sample, last accepted pattern.
   int         runlen = 0;
   logic [6:0] prev_s = 7'h00;
   logic [6:0] last_acc = 7'h00;
   bit         idle_m = 1'b1;
   exp_t       m = '0;

   function automatic int lookup(input logic [6:0] v);
      for (int i = 0; i < 10; i++) begin
         if (seg_tab[i] == v) return i;
      end
      return -1;
   endfunction

   // Predict outputs after one clock edge with the given rst/segment.
   task automatic model_step(input logic r, input logic [6:0] v);
      int d;
      m.up = 1'b0; m.dn = 1'b0; m.jmp = 1'b0;
      if (r) begin
         runlen = 0; prev_s = 7'h00; last_acc = 7'h00; idle_m = 1'b1; m = '0;
      end else begin
         if (v == prev_s) runlen++; else runlen = 1;
         prev_s = v;
         if (runlen == S && (idle_m || v != last_acc)) begin
            last_acc = v;
            idle_m = 1'b0;
            d = lookup(v);
            if (d < 0) begin
               m.ill = 1'b1;
               m.err = v;
            end else begin
               if (m.valid) begin
                  if (d == (int'(m.digit) + 1) % 10) begin
                     m.up = 1'b1;
                     if (m.upc != {CW{1'b1}}) m.upc = m.upc + 1'b1;
                  end else if (d == (int'(m.digit) + 9) % 10) begin
                     m.dn = 1'b1;
                     if (m.dnc != {CW{1'b1}}) m.dnc = m.dnc + 1'b1;
                  end else if (d != int'(m.digit)) begin
                     m.jmp = 1'b1;
                  end
               end
               m.digit = 4'(d);
               m.valid = 1'b1;
               m.ill   = 1'b0;
            end
         end
      end
   endtask

   task automatic apply(input logic r, input logic [6:0] v);
      @(negedge clk);
      rst = r;
      segment = v;
      model_step(r, v);
      q.push_back(m);
   endtask

   task automatic hold(input logic [6:0] v, input int n);
      for (int i = 0; i < n; i++) apply(1'b0, v);
   endtask

   // Monitor: after each active edge pop one prediction and compare all outputs.
   always @(posedge clk) begin
      exp_t e;
      exp_t a;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {digit, digit_valid, step_up, step_down, jump, illegal, err_pattern, up_cnt, down_cnt};
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL outputs t=%0t: got dig=%0d v=%b up=%b dn=%b jmp=%b ill=%b err=%h upc=%0d dnc=%0d; want dig=%0d v=%b up=%b dn=%b jmp=%b ill=%b err=%h upc=%0d dnc=%0d",
                     $time, a.digit, a.valid, a.up, a.dn, a.jmp, a.ill, a.err, a.upc, a.dnc,
                     e.digit, e.valid, e.up, e.dn, e.jmp, e.ill, e.err, e.upc, e.dnc);
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic, then drain and summarize.
   initial begin
      int cd;
      int nd;
      int k;
      apply(1'b1, 7'h00);
      apply(1'b1, 7'h00);
      hold(7'h3F, 4);          // first acceptance after exactly 4 edges
      hold(7'h06, 4);          // step up 0->1
      hold(7'h3F, 4);          // step down 1->0
      hold(7'h6F, 4);          // wrap 0->9 down
      hold(7'h3F, 4);          // wrap 9->0 up
      hold(7'h5B, 4);          // jump 0->2
      hold(7'h4F, 3);          // glitch too short
      hold(7'h5B, 4);          // back to accepted pattern: no event
      hold(7'h4F, 4);          // step up 2->3
      hold(7'h5B, 4);
      hold(7'h00, 4);          // blank is illegal
      hold(7'h66, 4);          // jump 2->4 from fault
      hold(7'h6D, 4); hold(7'h7D, 4); hold(7'h07, 4); hold(7'h7F, 4); hold(7'h6F, 4);
      hold(7'h3F, 2);
      apply(1'b1, 7'h3F);      // reset mid-run
      hold(7'h3F, 4);          // needs a fresh 4-edge run
      hold(7'h12, 4);          // illegal from track
      hold(7'h34, 4);          // different illegal
      hold(7'h3F, 4);
      cd = 0;
      for (int it = 0; it < 300; it++) begin
         k = $urandom_range(0, 39);
         if (k == 0) begin
            apply(1'b1, 7'($urandom));
         end else if (k < 5) begin
            hold(7'($urandom), $urandom_range(1, 6));
         end else if (k < 10) begin
            hold(seg_tab[$urandom_range(0, 9)], $urandom_range(1, 3));
         end else begin
            if (k < 22) nd = (cd + 1) % 10;
            else if (k < 34) nd = (cd + 9) % 10;
            else nd = $urandom_range(0, 9);
            hold(seg_tab[nd], $urandom_range(1, 6));
            cd = nd;
         end
      end
      hold(seg_tab[0], 6);
      for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d predictions left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
